// File: rtl/usb_serial_in_sched.sv
// USB serial IN-path scheduler: buffers uart-style tx bytes in a small FWFT FIFO and
// packs them into IN-endpoint packets, closing on size/idle/backpressure, with ZLP after full drains.
module usb_serial_in_sched #(
    parameter int FIFO_AW      = 4,
    parameter int MAX_PACKET   = 32,
    parameter int FLUSH_CYCLES = 48000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_tx_data,
    input  logic       uart_tx_strobe,
    output logic       uart_tx_ready,
    output logic       tx_overflow,
    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    output logic       in_ep_stall,
    input  logic       in_ep_acked
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int TW    = $clog2(FLUSH_CYCLES + 1);
    localparam int PW    = $clog2(MAX_PACKET + 1);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_MAX = TW'(FLUSH_CYCLES - 1);
    localparam logic [PW-1:0] PKT_MAX   = PW'(MAX_PACKET);
    localparam logic [PW-1:0] PKT_LAST  = PW'(MAX_PACKET - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DONE,
        WAIT_ACK
    } state_t;

    state_t state, state_next;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic [TW-1:0]      timer;
    logic [PW-1:0]      pkt_cnt;
    logic               zlp_pending;
    logic               overflow_q;

    logic push;
    logic put_ok;
    logic fifo_nonempty;
    logic timer_expired;

    // Readiness comes from the registered count only, so a pop cannot rescue a push into a full FIFO.
    assign uart_tx_ready = (count != FULL_CNT);
    assign push          = uart_tx_strobe && uart_tx_ready;
    assign fifo_nonempty = (count != '0);
    assign timer_expired = (timer == TIMER_MAX);
    assign put_ok        = (state == FILL) && in_ep_data_free && fifo_nonempty && (pkt_cnt < PKT_MAX);
    assign count_next    = count + CW'(push) - CW'(put_ok);
    assign tx_overflow   = overflow_q;
    assign in_ep_stall   = 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (put_ok) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            count <= count_next;
            if (uart_tx_strobe && !uart_tx_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Idle-flush timer only advances while waiting in IDLE with data buffered.
    always_ff @(posedge clk) begin
        if (reset || push || !fifo_nonempty) begin
            timer <= '0;
        end else if (state == IDLE && !timer_expired) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pkt_cnt     <= '0;
            zlp_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (put_ok) begin
                pkt_cnt <= pkt_cnt + PW'(1);
            end
            if (state == WAIT_ACK && in_ep_acked) begin
                zlp_pending <= (pkt_cnt == PKT_MAX) && !fifo_nonempty;
                pkt_cnt     <= '0;
            end
        end
    end

    always_comb begin
        state_next      = state;
        in_ep_req       = 1'b0;
        in_ep_data_put  = 1'b0;
        in_ep_data      = 8'h00;
        in_ep_data_done = 1'b0;
        case (state)
            IDLE: begin
                if ((32'(count) >= 32'(MAX_PACKET)) || (fifo_nonempty && timer_expired) || zlp_pending) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                in_ep_req = 1'b1;
                if (in_ep_grant) begin
                    state_next = zlp_pending ? DONE : FILL;
                end
            end
            FILL: begin
                in_ep_req      = 1'b1;
                in_ep_data_put = put_ok;
                if (put_ok) begin
                    in_ep_data = mem[rd_ptr];
                end
                if ((put_ok && pkt_cnt == PKT_LAST) || (pkt_cnt == PKT_MAX) || (count_next == '0) ||
                    (!in_ep_data_free && fifo_nonempty)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                in_ep_req       = 1'b1;
                in_ep_data_done = 1'b1;
                state_next      = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (in_ep_acked) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_serial_in_sched.sv
// Self-checking bench for usb_serial_in_sched: directed scenarios plus randomized traffic,
// checked against a queue-based model of accepted bytes, packet lengths and ZLP rules.
`timescale 1ns/1ps
module tb_usb_serial_in_sched;
    localparam int FIFO_AW    = 4;
    localparam int DEPTH      = 16;
    localparam int MAX_PACKET = 32;
    localparam int FLUSH      = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_tx_data;
    logic       uart_tx_strobe;
    logic       uart_tx_ready;
    logic       tx_overflow;
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    logic       grant_en;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         lens[$];
    int         pkt_len = 0;
    int         last_len = 0;
    int         n_put = 0;
    int         n_done = 0;
    int         n_ack = 0;
    int         ack_delay = 0;
    bit         wait_ack = 0;
    bit         zlp_exp = 0;
    bit         ovf_exp = 0;
    bit         prev_done = 0;

    always #5 clk = ~clk;

    assign in_ep_grant = in_ep_req && grant_en;

    usb_serial_in_sched #(
        .FIFO_AW(FIFO_AW),
        .MAX_PACKET(MAX_PACKET),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_tx_data(uart_tx_data),
        .uart_tx_strobe(uart_tx_strobe),
        .uart_tx_ready(uart_tx_ready),
        .tx_overflow(tx_overflow),
        .in_ep_req(in_ep_req),
        .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data),
        .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall),
        .in_ep_acked(in_ep_acked)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int lenAt(input int idx);
        if (idx < lens.size()) return lens[idx];
        return -1;
    endfunction

    // Reference model: accepted bytes must leave in order, packets obey the size and ZLP rules.
    always @(negedge clk) begin
        bit model_ready;
        if (reset) begin
            exp_q.delete();
            pkt_len   = 0;
            wait_ack  = 0;
            zlp_exp   = 0;
            ovf_exp   = 0;
            prev_done = 0;
        end else begin
            model_ready = (exp_q.size() < DEPTH);
            checkOutput("tx_ready", uart_tx_ready, model_ready);
            checkOutput("tx_overflow", tx_overflow, ovf_exp);
            checkOutput("stall", in_ep_stall, 0);
            checkOutput("done_pulse", in_ep_data_done & prev_done, 0);
            if (wait_ack) begin
                checkOutput("req_in_wait_ack", in_ep_req, 0);
                if (in_ep_acked) begin
                    zlp_exp  = (last_len == MAX_PACKET) && (exp_q.size() == 0);
                    wait_ack = 0;
                    n_ack++;
                end
            end
            if (in_ep_data_put) begin
                checkOutput("put_has_data", exp_q.size() > 0, 1);
                checkOutput("put_free", in_ep_data_free, 1);
                if (exp_q.size() > 0) checkOutput("put_byte", in_ep_data, exp_q.pop_front());
                pkt_len++;
                n_put++;
                checkOutput("pkt_len_max", pkt_len <= MAX_PACKET, 1);
            end else begin
                checkOutput("idle_data", in_ep_data, 0);
            end
            if (in_ep_data_done) begin
                checkOutput("done_no_put", in_ep_data_put, 0);
                if (zlp_exp) checkOutput("zlp_len", pkt_len, 0);
                lens.push_back(pkt_len);
                last_len = pkt_len;
                pkt_len  = 0;
                wait_ack = 1;
                n_done++;
            end
            if (uart_tx_strobe && !model_ready) ovf_exp = 1;
            if (uart_tx_strobe && model_ready) exp_q.push_back(uart_tx_data);
            prev_done = in_ep_data_done;
        end
    end

    // Host side: acknowledge each packet one to four cycles after its close.
    initial begin
        in_ep_acked = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            in_ep_acked = 1'b0;
            if (reset) begin
                ack_delay = 0;
            end else if (ack_delay > 0) begin
                ack_delay--;
                if (ack_delay == 0) in_ep_acked = 1'b1;
            end
            if (!reset && in_ep_data_done) ack_delay = $urandom_range(1, 4);
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        int guard = 0;
        while (!uart_tx_ready && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("push_ready", uart_tx_ready, 1);
        uart_tx_strobe = 1'b1;
        uart_tx_data   = b;
        @(posedge clk);
        #1;
        uart_tx_strobe = 1'b0;
    endtask

    task automatic waitReq(input int budget, output int cycles);
        cycles = 0;
        while (!in_ep_req && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic waitAcks(input int target, input int budget, input string tag);
        int c = 0;
        while (n_ack < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput(tag, n_ack, target);
    endtask

    task automatic waitPuts(input int target, input int budget);
        int c = 0;
        while (n_put < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("put_progress", n_put >= target, 1);
    endtask

    initial begin
        int lat;
        int base;
        int pbase;
        int dbase;
        int c;
        reset           = 1'b1;
        uart_tx_strobe  = 1'b0;
        uart_tx_data    = 8'h00;
        in_ep_data_free = 1'b1;
        grant_en        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", uart_tx_ready, 1);
        checkOutput("rst_overflow", tx_overflow, 0);
        checkOutput("rst_req", in_ep_req, 0);
        checkOutput("rst_put", in_ep_data_put, 0);
        checkOutput("rst_done", in_ep_data_done, 0);
        checkOutput("rst_data", in_ep_data, 0);
        reset = 1'b0;

        // Short packet forced out by the idle timer.
        base = lens.size();
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        applyStimulus(8'h43);
        waitReq(FLUSH + 20, lat);
        checkOutput("flush_latency", lat, FLUSH);
        waitAcks(1, 200, "t1_ack");
        checkOutput("t1_len", lenAt(base), 3);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t1_no_zlp", in_ep_req, 0);

        // Full-size packet that drains the FIFO, followed by a ZLP.
        base = lens.size();
        for (int i = 0; i < 32; i++) applyStimulus(8'(i));
        waitAcks(3, 1000, "t2_acks");
        checkOutput("t2_full_len", lenAt(base), MAX_PACKET);
        checkOutput("t2_zlp_len", lenAt(base + 1), 0);

        // Overflow while the endpoint is withheld; drop on a full-FIFO pop cycle.
        base     = lens.size();
        grant_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            uart_tx_strobe = 1'b1;
            uart_tx_data   = 8'(8'h80 + i);
            @(posedge clk);
            #1;
        end
        uart_tx_strobe = 1'b0;
        checkOutput("t3_ready_low", uart_tx_ready, 0);
        checkOutput("t3_overflow", tx_overflow, 1);
        waitReq(FLUSH + 50, lat);
        checkOutput("t3_req", in_ep_req, 1);
        repeat (100) @(posedge clk);
        #1;
        grant_en       = 1'b1;
        uart_tx_strobe = 1'b1;
        uart_tx_data   = 8'hEE;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        uart_tx_strobe = 1'b0;
        checkOutput("t3_ready_after_pop", uart_tx_ready, 1);
        waitAcks(4, 200, "t3_ack");
        checkOutput("t3_len", lenAt(base), 16);

        // Endpoint backpressure closes a packet early; the rest follows after the ack.
        base     = lens.size();
        grant_en = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'h60 + i));
        waitReq(FLUSH + 50, lat);
        pbase    = n_put;
        dbase    = n_done;
        grant_en = 1'b1;
        waitPuts(pbase + 5, 100);
        in_ep_data_free = 1'b0;
        c = 0;
        while (n_done == dbase && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        in_ep_data_free = 1'b1;
        waitAcks(6, 300, "t4_acks");
        checkOutput("t4_first_len", lenAt(base), 5);
        checkOutput("t4_second_len", lenAt(base + 1), 5);

        // Reset in the middle of a packet.
        grant_en = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'h70 + i));
        waitReq(FLUSH + 50, lat);
        pbase    = n_put;
        grant_en = 1'b1;
        waitPuts(pbase + 3, 100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_req", in_ep_req, 0);
        checkOutput("t5_put", in_ep_data_put, 0);
        checkOutput("t5_ready", uart_tx_ready, 1);
        checkOutput("t5_overflow", tx_overflow, 0);
        checkOutput("t5_done", in_ep_data_done, 0);
        reset = 1'b0;
        repeat (FLUSH + 10) @(posedge clk);
        #1;
        checkOutput("t5_fifo_empty", in_ep_req, 0);

        // Randomized traffic: light load first, then heavy load with endpoint backpressure.
        for (int i = 0; i < 4000; i++) begin
            uart_tx_strobe  = ($urandom_range(0, 99) < ((i < 2000) ? 40 : 90));
            uart_tx_data    = 8'($urandom);
            in_ep_data_free = ($urandom_range(0, 99) < ((i < 2000) ? 90 : 60));
            grant_en        = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        uart_tx_strobe  = 1'b0;
        in_ep_data_free = 1'b1;
        grant_en        = 1'b1;
        c = 0;
        while (!(exp_q.size() == 0 && !wait_ack && !zlp_exp && !in_ep_req) && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("drain_empty", exp_q.size(), 0);
        checkOutput("drain_idle", in_ep_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
